// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Control side of the 16-bit operand-forwarding path of the 5-stage CPU.
// Tracks the destination registers of in-flight instructions and produces
// registered per-operand selects for the EX-stage 5:1 operand muxes, plus a
// combinational one-cycle load-use stall request.
//
// Mux encoding {top, bot} (decoded in priority order):
//   bot=10        -> in4 immediate
//   top=1         -> in1 EX/MEM result
//   bot=00        -> in2 MEM/WB result
//   bot=01        -> in3 WB+1 result
//   top=0, bot=11 -> in0 register file
//
// Parameters
//   REG_AW   register address width (2**REG_AW architectural registers)
//   R0_ZERO  1: register 0 is hard-wired zero and never a forwarding match
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   id_valid                  ID holds a real instruction
//   id_rs1 / id_use_rs1       operand A source register / operand A used
//   id_rs2 / id_use_rs2       operand B source register / operand B used
//   id_use_imm                operand B takes the immediate
//   id_rd / id_wr / id_load   destination, writes-rd flag, load flag
//   flush                     squash the instruction in ID
//   stall                     hold PC and IF/ID, bubble into ID/EX
//   a_sel_top, a_sel_bot      operand A mux select (registered)
//   b_sel_top, b_sel_bot      operand B mux select (registered)
//   stall_count               saturating stall-cycle counter (HAZ_PERF_EN only)
//
// Configuration macro
//   HAZ_PERF_EN  when defined, adds the stall_count port and counter.
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl #(
    parameter int REG_AW  = 4,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_imm,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr,
    input  logic              id_load,
    input  logic              flush,
    output logic              stall,
    output logic              a_sel_top,
    output logic [1:0]        a_sel_bot,
    output logic              b_sel_top,
    output logic [1:0]        b_sel_bot
`ifdef HAZ_PERF_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    typedef enum logic [2:0] {
        SEL_IN0 = 3'b011,
        SEL_IN1 = 3'b111,
        SEL_IN2 = 3'b000,
        SEL_IN3 = 3'b001,
        SEL_IN4 = 3'b010
    } sel_e;

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [REG_AW-1:0] rd;
    } rec_t;

    // The load flag only matters while the record is the one just ahead of
    // ID, so it is kept beside IDEX instead of travelling down the pipe.
    // A record leaving MEMWB has no forwarding source any more (WB+1 is the
    // oldest mux input), so nothing past MEMWB is stored.
    rec_t idex, exmem, memwb;
    logic idex_load;

    sel_e a_next, b_next;
    logic bubble;

    function automatic logic match(input rec_t r, input logic [REG_AW-1:0] s);
        return r.valid & r.wr & (r.rd == s) & ~(R0_ZERO & (s == '0));
    endfunction

    // Youngest in-flight writer wins.
    function automatic sel_e pick(input rec_t r_idex, input rec_t r_exmem,
                                  input rec_t r_memwb, input logic [REG_AW-1:0] s);
        if (match(r_idex, s))
            return SEL_IN1;
        else if (match(r_exmem, s))
            return SEL_IN2;
        else if (match(r_memwb, s))
            return SEL_IN3;
        else
            return SEL_IN0;
    endfunction

    // Load-use stall; a flush suppresses it because the consumer is squashed.
    always_comb begin
        stall = id_valid & ~flush & idex_load &
                ((match(idex, id_rs1) & id_use_rs1) |
                 (match(idex, id_rs2) & id_use_rs2 & ~id_use_imm));
    end

    always_comb begin
        a_next = SEL_IN0;
        b_next = SEL_IN0;
        bubble = ~id_valid | flush | stall;
        if (id_use_rs1)
            a_next = pick(idex, exmem, memwb, id_rs1);
        if (id_use_imm)
            b_next = SEL_IN4;
        else if (id_use_rs2)
            b_next = pick(idex, exmem, memwb, id_rs2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex      <= '0;
            exmem     <= '0;
            memwb     <= '0;
            idex_load <= 1'b0;
            a_sel_top <= SEL_IN0[2];
            a_sel_bot <= SEL_IN0[1:0];
            b_sel_top <= SEL_IN0[2];
            b_sel_bot <= SEL_IN0[1:0];
        end else begin
            memwb <= exmem;
            exmem <= idex;
            if (bubble) begin
                idex      <= '0;
                idex_load <= 1'b0;
                a_sel_top <= SEL_IN0[2];
                a_sel_bot <= SEL_IN0[1:0];
                b_sel_top <= SEL_IN0[2];
                b_sel_bot <= SEL_IN0[1:0];
            end else begin
                idex.valid <= 1'b1;
                idex.wr    <= id_wr;
                idex.rd    <= id_rd;
                idex_load  <= id_load;
                a_sel_top  <= a_next[2];
                a_sel_bot  <= a_next[1:0];
                b_sel_top  <= b_next[2];
                b_sel_bot  <= b_next[1:0];
            end
        end
    end

`ifdef HAZ_PERF_EN
    // Saturating count of stall cycles; cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (stall && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
//
// Directed testbench for fwd_hazard_ctrl. A second instance built with
// R0_ZERO=0 shares the same stimulus and is checked where register 0
// forwarding is exercised. Mux selects are decoded back to an input index
// (0..4) in the documented priority order before comparison.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_rs1;
    logic [3:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_imm;
    logic       id_use_rs2;
    logic [3:0] id_rd;
    logic       id_wr;
    logic       id_load;
    logic       flush;
    logic       stall;
    logic       a_sel_top;
    logic [1:0] a_sel_bot;
    logic       b_sel_top;
    logic [1:0] b_sel_bot;
    logic       stall2;
    logic       a_sel_top2;
    logic [1:0] a_sel_bot2;
    logic       b_sel_top2;
    logic [1:0] b_sel_bot2;
`ifdef HAZ_PERF_EN
    logic [15:0] stall_count;
    logic [15:0] stall_count2;
`endif

    int   vectors;
    int   miscompares;
    logic stall_seen;

    fwd_hazard_ctrl #(.REG_AW(4), .R0_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_imm(id_use_imm), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load), .flush(flush),
        .stall(stall),
        .a_sel_top(a_sel_top), .a_sel_bot(a_sel_bot),
        .b_sel_top(b_sel_top), .b_sel_bot(b_sel_bot)
`ifdef HAZ_PERF_EN
        , .stall_count(stall_count)
`endif
    );

    fwd_hazard_ctrl #(.REG_AW(4), .R0_ZERO(1'b0)) dut_r0 (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_imm(id_use_imm), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load), .flush(flush),
        .stall(stall2),
        .a_sel_top(a_sel_top2), .a_sel_bot(a_sel_bot2),
        .b_sel_top(b_sel_top2), .b_sel_bot(b_sel_bot2)
`ifdef HAZ_PERF_EN
        , .stall_count(stall_count2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decode {top, bot} to the selected mux input in priority order.
    function automatic logic [15:0] decode(input logic top, input logic [1:0] bot);
        if ($isunknown({top, bot}))
            return 16'hxxxx;
        else if (bot == 2'b10)
            return 16'd4;
        else if (top)
            return 16'd1;
        else if (bot == 2'b00)
            return 16'd2;
        else if (bot == 2'b01)
            return 16'd3;
        else
            return 16'd0;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkSel(input string tag, input int exp_a, input int exp_b);
        checkOutput({tag, ".a"}, decode(a_sel_top, a_sel_bot), 16'(exp_a));
        checkOutput({tag, ".b"}, decode(b_sel_top, b_sel_bot), 16'(exp_b));
    endtask

    task automatic driveInputs(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                               input logic u1, input logic uimm, input logic u2,
                               input logic [3:0] rd, input logic wr, input logic ld,
                               input logic fl);
        id_valid   = v;
        id_rs1     = rs1;
        id_rs2     = rs2;
        id_use_rs1 = u1;
        id_use_imm = uimm;
        id_use_rs2 = u2;
        id_rd      = rd;
        id_wr      = wr;
        id_load    = ld;
        flush      = fl;
    endtask

    // Present one ID instruction, capture the same-cycle stall, then clock it
    // into EX and settle just after the edge so registered selects are visible.
    task automatic applyStimulus(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                                 input logic u1, input logic uimm, input logic u2,
                                 input logic [3:0] rd, input logic wr, input logic ld,
                                 input logic fl);
        driveInputs(v, rs1, rs2, u1, uimm, u2, rd, wr, ld, fl);
        #1;
        stall_seen = stall;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        stall_seen  = 1'b0;
        rst         = 1'b1;
        driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        $display("[TB] reset state");
        checkOutput("reset.stall", 16'(stall), 16'd0);
        checkSel("reset", 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] ALU chain");
        applyStimulus(1, 1, 2, 1, 0, 1, 3, 1, 0, 0);
        checkOutput("alu0.stall", 16'(stall_seen), 16'd0);
        checkSel("alu0", 0, 0);
        applyStimulus(1, 3, 5, 1, 0, 1, 4, 1, 0, 0);
        checkOutput("alu1.stall", 16'(stall_seen), 16'd0);
        checkSel("alu1", 1, 0);
        applyStimulus(1, 3, 0, 1, 0, 1, 6, 1, 0, 0);
        checkSel("alu2", 2, 0);
        drain();

        $display("[TB] load-use");
        applyStimulus(1, 1, 0, 1, 1, 0, 2, 1, 1, 0);
        checkOutput("lw.stall", 16'(stall_seen), 16'd0);
        checkSel("lw", 0, 4);
        applyStimulus(1, 2, 2, 1, 0, 1, 7, 1, 0, 0);
        checkOutput("use0.stall", 16'(stall_seen), 16'd1);
        checkSel("use0", 0, 0);
        applyStimulus(1, 2, 2, 1, 0, 1, 7, 1, 0, 0);
        checkOutput("use1.stall", 16'(stall_seen), 16'd0);
        checkSel("use1", 2, 2);
`ifdef HAZ_PERF_EN
        checkOutput("use1.count", stall_count, 16'd1);
`endif
        drain();

        $display("[TB] immediate and r0");
        applyStimulus(1, 1, 2, 1, 0, 1, 0, 1, 0, 0);
        checkSel("wr0", 0, 0);
        applyStimulus(1, 0, 0, 1, 1, 0, 1, 1, 0, 0);
        checkSel("addi", 0, 4);
        checkOutput("addi.r0.a", decode(a_sel_top2, a_sel_bot2), 16'd1);
        checkOutput("addi.r0.b", decode(b_sel_top2, b_sel_bot2), 16'd4);
        drain();

        $display("[TB] priority");
        applyStimulus(1, 1, 2, 1, 0, 1, 5, 1, 0, 0);
        applyStimulus(1, 1, 2, 1, 0, 1, 5, 1, 0, 0);
        applyStimulus(1, 1, 2, 1, 0, 1, 5, 1, 0, 0);
        applyStimulus(1, 5, 6, 1, 0, 1, 9, 1, 0, 0);
        checkSel("prio3", 1, 0);
        drain();
        applyStimulus(1, 1, 2, 1, 0, 1, 5, 1, 0, 0);
        applyStimulus(1, 1, 2, 1, 0, 1, 5, 1, 0, 0);
        applyStimulus(1, 1, 2, 1, 0, 1, 5, 0, 0, 0);
        applyStimulus(1, 5, 6, 1, 0, 1, 9, 1, 0, 0);
        checkSel("prio2", 2, 0);
        drain();
        applyStimulus(1, 1, 2, 1, 0, 1, 5, 1, 0, 0);
        applyStimulus(1, 1, 2, 1, 0, 1, 5, 0, 0, 0);
        applyStimulus(1, 1, 2, 1, 0, 1, 5, 0, 0, 0);
        applyStimulus(1, 5, 6, 1, 0, 1, 9, 1, 0, 0);
        checkSel("prio1", 3, 0);
        drain();

        $display("[TB] flush");
        applyStimulus(1, 1, 0, 1, 1, 0, 2, 1, 1, 0);
        applyStimulus(1, 2, 0, 1, 1, 0, 8, 1, 1, 1);
        checkOutput("flush.stall", 16'(stall_seen), 16'd0);
        checkSel("flush", 0, 0);
        applyStimulus(1, 8, 2, 1, 0, 1, 10, 1, 0, 0);
        checkOutput("postflush.stall", 16'(stall_seen), 16'd0);
        checkSel("postflush", 0, 2);
        drain();

        $display("[TB] reset mid-stall");
        applyStimulus(1, 1, 0, 1, 1, 0, 2, 1, 1, 0);
        driveInputs(1, 2, 2, 1, 0, 1, 7, 1, 0, 0);
        #1;
        checkOutput("midrst.pre.stall", 16'(stall), 16'd1);
        rst = 1'b1;
        #1;
        checkOutput("midrst.stall", 16'(stall), 16'd0);
        checkSel("midrst", 0, 0);
`ifdef HAZ_PERF_EN
        checkOutput("midrst.count", stall_count, 16'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1, 2, 2, 1, 0, 1, 7, 1, 0, 0);
        checkOutput("postrst.stall", 16'(stall_seen), 16'd0);
        checkSel("postrst", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
